// File: rtl/txt_render_attr.sv
// txt_render_attr -- text-mode renderer with per-cell colour attributes,
// blinking characters and a hardware blinking cursor.
//
// Takes pixel coordinates from the shared VGA timing block. For each cell it
// prefetches the next cell's character/attribute word from display memory and
// the matching glyph row from font memory. Both memories have a 1-cycle
// synchronous read. It then drives a registered 4-bit colour index that
// trails the pixel coordinates by exactly one clock.
//
// Ports
//   clk        pixel clock
//   clr        synchronous active-high reset
//   pix_x      current pixel column (wraps H_TOTAL-1 -> 0)
//   pix_y      current pixel line
//   de         active-video flag for (pix_x, pix_y)
//   dis_addr   display memory address (row*COLS + col)
//   dis_en     display memory read enable (1-cycle pulse)
//   dis_dat    display word: [7:0] char, [11:8] fg, [14:12] bg, [15] blink
//   font_addr  font memory address {char, glyph_row}
//   font_en    font memory read enable (1-cycle pulse)
//   font_dat   glyph row, MSB = leftmost pixel
//   cur_en     cursor enable
//   cur_col    cursor column
//   cur_row    cursor row
//   out_color  colour index
//   out_de     de delayed to line up with out_color
module txt_render_attr #(
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [9:0]                    pix_x,
    input  logic [9:0]                    pix_y,
    input  logic                          de,
    output logic [ADDR_W-1:0]             dis_addr,
    output logic                          dis_en,
    input  logic [15:0]                   dis_dat,
    output logic [8+$clog2(GLYPH_H)-1:0]  font_addr,
    output logic                          font_en,
    input  logic [GLYPH_W-1:0]            font_dat,
    input  logic                          cur_en,
    input  logic [6:0]                    cur_col,
    input  logic [4:0]                    cur_row,
    output logic [3:0]                    out_color,
    output logic                          out_de
);

    localparam int PH_W    = $clog2(GLYPH_W);
    localparam int GR_W    = $clog2(GLYPH_H);
    localparam int H_CELLS = H_TOTAL / GLYPH_W;
    localparam int BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Pipeline slots within a cell, named by the pixel phase sampled at the edge.
    localparam logic [PH_W-1:0] PH_DIS  = PH_W'(GLYPH_W - 6);
    localparam logic [PH_W-1:0] PH_FONT = PH_W'(GLYPH_W - 4);
    localparam logic [PH_W-1:0] PH_GLY  = PH_W'(GLYPH_W - 2);
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(GLYPH_W - 1);

    // Colour of one pixel from the current glyph row and attribute. A blinking
    // character is hidden during blink phase 0; a cursor hit swaps fg/bg
    // during blink phase 1.
    function automatic logic [3:0] resolve_color(
        input logic [GLYPH_W-1:0] glyph,
        input logic [PH_W-1:0]    idx,
        input logic [7:0]         attr,
        input logic               hit,
        input logic               phase
    );
        logic       on;
        logic [3:0] fg;
        logic [3:0] bg;
        on = glyph[idx] & ~(attr[7] & ~phase);
        fg = attr[3:0];
        bg = {1'b0, attr[6:4]};
        if (hit && phase)
            return on ? bg : fg;
        else
            return on ? fg : bg;
    endfunction

    // Target (next) cell decode
    logic [PH_W-1:0]   ph;
    logic [9:0]        cell_x;
    logic [9:0]        nc_raw;
    logic              wrap;
    logic [9:0]        nc;
    logic [9:0]        y_next;
    logic [9:0]        line;
    logic [9:0]        row;
    logic [GR_W-1:0]   gr;
    logic              tgt_valid;
    logic [ADDR_W-1:0] tgt_addr;
    logic              frame_tick;

    assign ph         = pix_x[PH_W-1:0];
    assign cell_x     = pix_x >> PH_W;
    assign nc_raw     = cell_x + 10'd1;
    assign wrap       = (nc_raw >= 10'(H_CELLS));
    assign nc         = wrap ? 10'd0 : nc_raw;
    assign y_next     = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
    assign line       = wrap ? y_next : pix_y;
    assign row        = line >> GR_W;
    assign gr         = line[GR_W-1:0];
    assign tgt_valid  = (nc < 10'(COLS)) && (row < 10'(ROWS));
    assign tgt_addr   = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(nc);
    assign frame_tick = (pix_x == 10'd0) && (pix_y == 10'd0);

    // Pipeline state
    logic [9:0]         nc_p0;
    logic [9:0]         row_p0;
    logic [GR_W-1:0]    gr_p0;
    logic               vld_p0;
    logic [7:0]         attr_buf_p1;
    logic [GLYPH_W-1:0] glyph_buf_p2;
    logic [GLYPH_W-1:0] shreg;
    logic [7:0]         attr_cur;
    logic               cell_valid;
    logic               cur_hit;
    logic [BC_W-1:0]    blink_cnt;
    logic               blink_phase;

    logic [PH_W-1:0] bit_idx;
    logic [3:0]      pix_color;

    assign bit_idx = PH_W'(GLYPH_W - 1) - ph;

    always_comb begin
        pix_color = 4'd0;
        if (de && cell_valid)
            pix_color = resolve_color(shreg, bit_idx, attr_cur, cur_hit, blink_phase);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dis_addr     <= '0;
            dis_en       <= 1'b0;
            font_addr    <= '0;
            font_en      <= 1'b0;
            nc_p0        <= '0;
            row_p0       <= '0;
            gr_p0        <= '0;
            vld_p0       <= 1'b0;
            attr_buf_p1  <= '0;
            glyph_buf_p2 <= '0;
            shreg        <= '0;
            attr_cur     <= '0;
            cell_valid   <= 1'b0;
            cur_hit      <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            out_color    <= '0;
            out_de       <= 1'b0;
        end else begin
            dis_en  <= 1'b0;
            font_en <= 1'b0;

            // Stage p0: latch target cell, issue display read
            if (ph == PH_DIS) begin
                nc_p0    <= nc;
                row_p0   <= row;
                gr_p0    <= gr;
                vld_p0   <= tgt_valid;
                dis_addr <= tgt_addr;
                dis_en   <= tgt_valid;
            end

            // Stage p1: display word back, issue font read, keep attribute
            if (ph == PH_FONT && vld_p0) begin
                font_addr   <= {dis_dat[7:0], gr_p0};
                font_en     <= 1'b1;
                attr_buf_p1 <= dis_dat[15:8];
            end

            // Stage p2: glyph row back
            if (ph == PH_GLY && vld_p0)
                glyph_buf_p2 <= font_dat;

            // Cell boundary: hand prefetched cell to the output stage
            if (ph == PH_LOAD) begin
                shreg      <= glyph_buf_p2;
                attr_cur   <= attr_buf_p1;
                cell_valid <= vld_p0;
                cur_hit    <= cur_en && (nc_p0 == {3'b000, cur_col})
                              && (row_p0 == {5'b00000, cur_row})
                              && (gr_p0 >= GR_W'(GLYPH_H - 2));
            end

            if (frame_tick) begin
                if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // Output stage: one clock behind pix_x/pix_y
            out_color <= pix_color;
            out_de    <= de;
        end
    end

endmodule

// File: tb/tb_txt_render_attr.sv
// Bench for txt_render_attr: directed pixel spans with hand-computed colours.
// Stimulus pushes expected results into a queue. A monitor pops one entry
// per clock after the active edge and compares it with the DUT outputs.
module tb_txt_render_attr;

    localparam int GW = 8;
    localparam int V  = 525;
    localparam int HC = 100;

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        de;
    logic [11:0] dis_addr;
    logic        dis_en;
    logic [15:0] dis_dat;
    logic [11:0] font_addr;
    logic        font_en;
    logic [7:0]  font_dat;
    logic        cur_en;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic [3:0]  out_color;
    logic        out_de;

    always #5 clk = ~clk;

    txt_render_attr dut (
        .clk(clk), .clr(clr), .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .dis_addr(dis_addr), .dis_en(dis_en), .dis_dat(dis_dat),
        .font_addr(font_addr), .font_en(font_en), .font_dat(font_dat),
        .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .out_color(out_color), .out_de(out_de)
    );

    // Synchronous-read memories
    logic [15:0] dmem [0:4095];
    logic [7:0]  fmem [0:4095];

    always @(posedge clk) begin
        if (dis_en)  dis_dat  <= dmem[dis_addr];
        if (font_en) font_dat <= fmem[font_addr];
    end

    typedef struct {
        string       nm;
        bit          co;
        logic [3:0]  col;
        logic        dv;
        bit          cm;
        logic        den;
        logic [11:0] da;
        logic        fen;
        logic [11:0] fa;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string nm, input bit co, input logic [3:0] col,
                                input logic dv, input bit cm, input logic den,
                                input logic [11:0] da, input logic fen, input logic [11:0] fa);
        exp_t e;
        e.nm = nm; e.co = co; e.col = col; e.dv = dv; e.cm = cm;
        e.den = den; e.da = da; e.fen = fen; e.fa = fa;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            if (mon_e.co) begin
                chk({mon_e.nm, " color"}, 32'(out_color), 32'(mon_e.col));
                chk({mon_e.nm, " de"}, 32'(out_de), 32'(mon_e.dv));
            end
            if (mon_e.cm) begin
                chk({mon_e.nm, " dis_en"}, 32'(dis_en), 32'(mon_e.den));
                if (mon_e.den) chk({mon_e.nm, " dis_addr"}, 32'(dis_addr), 32'(mon_e.da));
                chk({mon_e.nm, " font_en"}, 32'(font_en), 32'(mon_e.fen));
                if (mon_e.fen) chk({mon_e.nm, " font_addr"}, 32'(font_addr), 32'(mon_e.fa));
            end
        end
    end

    task automatic step(input int x, input int y, input logic d, input logic c, input exp_t e);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        de    = d;
        clr   = c;
        sbq.push_back(e);
    endtask

    // Frame ticks: (0,0) then (1,0), blanked.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1'b0, 1'b0, mk("tick", 1, 4'h0, 1'b0, 0, 0, 0, 0, 0));
            step(1, 0, 1'b0, 1'b0, mk("tick", 1, 4'h0, 1'b0, 0, 0, 0, 0, 0));
        end
    endtask

    // Lead-in cell (blanked, prefetching the target) followed by the target
    // cell. pat holds 8 expected colours, pixel 0 in the top nibble.
    task automatic cell_span(input string nm, input int y, input int col, input logic dcell,
                             input logic [31:0] pat, input bit pref,
                             input logic [11:0] da, input logic [11:0] fa);
        int ly;
        int lx;
        ly = (col == 0) ? ((y == 0) ? V - 1 : y - 1) : y;
        lx = (col == 0) ? (HC - 1) * GW : (col - 1) * GW;
        for (int p = 0; p < GW; p++)
            step(lx + p, ly, 1'b0, 1'b0,
                 mk($sformatf("%s lead%0d", nm, p), 1, 4'h0, 1'b0, 1,
                    pref && (p == 2), da, pref && (p == 4), fa));
        for (int p = 0; p < GW; p++)
            step(col * GW + p, y, dcell, 1'b0,
                 mk($sformatf("%s px%0d", nm, p), 1, dcell ? pat[31-4*p -: 4] : 4'h0,
                    dcell, 0, 0, 0, 0, 0));
    endtask

    initial begin
        clr = 1'b1; de = 1'b0; pix_x = 10'd0; pix_y = 10'd100;
        cur_en = 1'b0; cur_col = 7'd3; cur_row = 5'd2;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = 16'h0000;
            fmem[i] = 8'h00;
        end
        dmem[0]    = 16'h0F41;   // cell (0,0)
        dmem[2399] = 16'h1220;   // cell (79,29): fg=2, bg=1
        dmem[163]  = 16'h1E41;   // cell (3,2): fg=E, bg=1
        dmem[85]   = 16'h8F41;   // cell (5,1): blinking, fg=F, bg=0
        dmem[518]  = 16'h7F41;   // cell (38,6)
        dmem[519]  = 16'h0C41;   // cell (39,6): fg=C
        fmem[12'h410] = 8'h81;
        fmem[12'h414] = 8'hFF;
        fmem[12'h41D] = 8'h3C;
        fmem[12'h41E] = 8'hF0;
        fmem[12'h41F] = 8'h0F;
        fmem[12'h200] = 8'h00;

        repeat (3) @(negedge clk);
        clr = 1'b0;

        // Advance the blink counter so the mid-line reset must clear it
        tick(15);

        // Mid-line reset: clr for 3 clocks at line 100, x=300..302
        for (int x = 292; x < 300; x++) begin
            @(negedge clk);
            pix_x = 10'(x); pix_y = 10'd100; de = 1'b1; clr = 1'b0;
        end
        for (int x = 300; x < 303; x++)
            step(x, 100, 1'b1, 1'b1, mk("rst", 1, 4'h0, 1'b0, 1, 0, 0, 0, 0));
        // Cell 38 was prefetched before reset -> blank; cell 39 renders fg=C
        for (int x = 303; x < 312; x++)
            step(x, 100, 1'b1, 1'b0,
                 mk($sformatf("rst blank x%0d", x), 1, 4'h0, 1'b1, 1,
                    x == 306, 12'd519, x == 308, 12'h414));
        for (int x = 312; x < 320; x++)
            step(x, 100, 1'b1, 1'b0, mk($sformatf("post rst x%0d", x), 1, 4'hC, 1'b1, 0, 0, 0, 0, 0));

        // Cell (0,0), prefetched from the end of line 524 (1 frame tick)
        cell_span("c00", 0, 0, 1'b1, 32'hF000000F, 1, 12'd0, 12'h410);

        // Cell (79,29): blank glyph -> bg=1; cell 80 has no fetch and renders 0
        cell_span("c79", 464, 79, 1'b1, 32'h11111111, 1, 12'd2399, 12'h200);
        cell_span("c80", 464, 80, 1'b1, 32'h00000000, 0, 12'd0, 12'h000);

        // Blanking with nonzero data
        cell_span("blank", 46, 3, 1'b0, 32'h00000000, 1, 12'd163, 12'h41E);

        // Cursor at (3,2), blink phase 0: no swap
        cur_en = 1'b1;
        cell_span("cur13 p0", 45, 3, 1'b1, 32'h11EEEE11, 1, 12'd163, 12'h41D);
        cell_span("cur14 p0", 46, 3, 1'b1, 32'hEEEE1111, 1, 12'd163, 12'h41E);
        cell_span("cur15 p0", 47, 3, 1'b1, 32'h1111EEEE, 1, 12'd163, 12'h41F);
        cell_span("blk p0", 16, 5, 1'b1, 32'h00000000, 1, 12'd85, 12'h410);

        // 29 ticks since reset: still phase 0
        tick(28);
        cell_span("cur14 f29", 46, 3, 1'b1, 32'hEEEE1111, 1, 12'd163, 12'h41E);
        cell_span("blk f29", 16, 5, 1'b1, 32'h00000000, 1, 12'd85, 12'h410);

        // 30 ticks: phase 1 -> cursor rows 14-15 swapped, row 13 not; blink char shown
        tick(1);
        cell_span("cur14 f30", 46, 3, 1'b1, 32'h1111EEEE, 1, 12'd163, 12'h41E);
        cell_span("cur15 f30", 47, 3, 1'b1, 32'hEEEE1111, 1, 12'd163, 12'h41F);
        cell_span("cur13 f30", 45, 3, 1'b1, 32'h11EEEE11, 1, 12'd163, 12'h41D);
        cell_span("blk f30", 16, 5, 1'b1, 32'hF000000F, 1, 12'd85, 12'h410);
        cur_en = 1'b0;
        cell_span("curoff f30", 46, 3, 1'b1, 32'hEEEE1111, 1, 12'd163, 12'h41E);
        cur_en = 1'b1;

        // 59 ticks: still phase 1
        tick(29);
        cell_span("cur14 f59", 46, 3, 1'b1, 32'h1111EEEE, 1, 12'd163, 12'h41E);
        cell_span("blk f59", 16, 5, 1'b1, 32'hF000000F, 1, 12'd85, 12'h410);

        // 60 ticks: back to phase 0
        tick(1);
        cell_span("cur14 f60", 46, 3, 1'b1, 32'hEEEE1111, 1, 12'd163, 12'h41E);
        cell_span("blk f60", 16, 5, 1'b1, 32'h00000000, 1, 12'd85, 12'h410);

        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
